// File: rtl/mac16_dot_seq_if.sv
// Handshake bundle for mac16_dot_seq: command, operand stream and result ports.
// slave is the engine side, master is the producer/consumer side.
interface mac16_dot_seq_if #(
    parameter int unsigned LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic             res_ovf;
    logic             busy;

    modport slave (
        input  cmd_valid, cmd_len, in_valid, in_a, in_b, res_ready,
        output cmd_ready, in_ready, res_valid, res_data, res_ovf, busy
    );

    modport master (
        output cmd_valid, cmd_len, in_valid, in_a, in_b, res_ready,
        input  cmd_ready, in_ready, res_valid, res_data, res_ovf, busy
    );
endinterface

// File: rtl/mac16_dot_seq.sv
// Unsigned 16x16 multiply-accumulate dot-product sequencer around one MAC16-style DSP slice.
// Optional sticky accumulator carry flag on res_ovf: define DOTSEQ_OVF_EN.
module mac16_dot_seq #(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset,
    mac16_dot_seq_if.slave      bus
);
    localparam int unsigned DRAIN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    // DSP datapath: A/B input regs, multiplier pipeline reg, accumulator reg
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [31:0] mult_q, mult_d;
    logic [31:0] acc_q, acc_d;

    logic in_fire;
    logic oload;

`ifdef DOTSEQ_OVF_EN
    logic [32:0] acc_sum;
    assign acc_sum = {1'b0, acc_q} + {1'b0, mult_q};
`else
    logic [31:0] acc_sum;
    assign acc_sum = acc_q + mult_q;
`endif

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.in_ready  = (state_q == S_STREAM) && (rem_q != '0);
    assign bus.res_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.res_data  = acc_q;

    assign in_fire = bus.in_valid && bus.in_ready;
    assign oload   = (state_q == S_CLEAR);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        drain_d = drain_q;

        // Idle cycles feed zeros so the accumulator only ever adds 0 on bubbles
        a_d    = in_fire ? bus.in_a : '0;
        b_d    = in_fire ? bus.in_b : '0;
        mult_d = 32'(a_q) * 32'(b_q);
        acc_d  = oload ? '0 : acc_sum[31:0];

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    rem_d   = bus.cmd_len;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (rem_q == '0) begin
                    drain_d = DRAIN_W'(LATENCY - 1);
                    state_d = S_DRAIN;
                end else if (in_fire) begin
                    rem_d = rem_q - 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            drain_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            drain_q <= drain_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
        end
    end

`ifdef DOTSEQ_OVF_EN
    logic ovf_q, ovf_d;

    // Carry is collected on every accumulating edge, i.e. from the edge after CLEAR up to DONE entry
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == S_IDLE && bus.cmd_valid) begin
            ovf_d = 1'b0;
        end else if (state_q == S_STREAM || state_q == S_DRAIN) begin
            ovf_d = ovf_q | acc_sum[32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.res_ovf = ovf_q;
`else
    assign bus.res_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_mac16_dot_seq.sv
// Scoreboard bench for mac16_dot_seq: stimulus pushes expected sums, a monitor pops on result handshakes.
module tb_mac16_dot_seq;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned LATENCY = 3;
`ifdef DOTSEQ_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac16_dot_seq_if #(.LEN_W(LEN_W)) bus ();

    mac16_dot_seq #(.LEN_W(LEN_W), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    bit   force_low = 1'b0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    // Reference: exact integer dot product; low 32 bits are the result, anything above means a carry occurred
    function automatic exp_t model();
        exp_t e;
        longint unsigned s = 0;
        foreach (qa[i]) s += longint'(qa[i]) * longint'(qb[i]);
        e.data = s[31:0];
        e.ovf  = OVF_EN && (s[63:32] != 0);
        return e;
    endfunction

    // Consumer readiness: random backpressure unless held low
    initial begin
        bus.res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.res_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: a handshake seen here completes on the following rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.res_valid && bus.res_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_data", bus.res_data, e.data);
                    chk("res_ovf", bus.res_ovf, e.ovf);
                end
            end
        end
    end

    task automatic send_cmd(input int unsigned len);
        int unsigned t = 0;
        bus.cmd_len   = LEN_W'(len);
        bus.cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.cmd_ready && t < 500);
        if (!bus.cmd_ready) begin
            chk("cmd_timeout", 0, 1);
            finish_run();
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input int gap);
        int unsigned t = 0;
        int g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.in_ready && t < 500);
        if (!bus.in_ready) begin
            chk("in_timeout", 0, 1);
            finish_run();
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Issues one full vector from qa/qb; lat = edges from last acceptance (or cmd for len 0) to res_valid
    task automatic run_vec(input int gap, output int lat);
        int k = 0;
        sb_q.push_back(model());
        send_cmd(qa.size());
        foreach (qa[i]) send_pair(qa[i], qb[i], (i == 0) ? 0 : gap);
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus.res_valid && k < 100);
        if (!bus.res_valid) chk("res_timeout", 0, 1);
        lat = k;
    endtask

    task automatic wait_drain();
        int unsigned t = 0;
        while (sb_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);
    endtask

    initial begin
        int   lat;
        exp_t e;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_ovf", bus.res_ovf, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk);
        #1;

        qa = {16'd999};
        qb = {16'd12345};
        run_vec(0, lat);
        chk("len1_latency", lat, 1 + LATENCY);

        qa = {16'd1, 16'd3, 16'd5};
        qb = {16'd2, 16'd4, 16'd6};
        run_vec(2, lat);

        qa = {};
        qb = {};
        run_vec(0, lat);
        chk("len0_latency", lat, 2 + LATENCY);

        qa = {16'hFFFF, 16'hFFFF};
        qb = {16'hFFFF, 16'hFFFF};
        run_vec(0, lat);

        wait_drain();
        force_low = 1'b1;
        qa = {16'd100, 16'd300};
        qb = {16'd200, 16'd400};
        e = model();
        run_vec(1, lat);
        repeat (10) begin
            @(negedge clk);
            chk("hold_res_valid", bus.res_valid, 1);
            chk("hold_res_data", bus.res_data, e.data);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
        end
        force_low = 1'b0;
        @(posedge clk);
        #1;
        qa = {16'd2};
        qb = {16'd3};
        run_vec(0, lat);

        wait_drain();
        send_cmd(4);
        send_pair(16'd1000, 16'd1000, 0);
        send_pair(16'd2000, 16'd2000, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_res_valid", bus.res_valid, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_res_data", bus.res_data, 0);
        qa = {16'd7};
        qb = {16'd7};
        run_vec(0, lat);

        for (int v = 0; v < 30; v++) begin
            int unsigned len = (v == 29) ? 255 : $urandom_range(0, 12);
            qa = {};
            qb = {};
            for (int unsigned i = 0; i < len; i++) begin
                qa.push_back(16'($urandom_range(0, 65535)));
                qb.push_back(16'($urandom_range(0, 65535)));
            end
            run_vec(-1, lat);
            if (len != 0) chk("rand_latency", lat, 1 + LATENCY);
        end

        wait_drain();
        finish_run();
    end

    initial begin
        #2000000;
        chk("watchdog", 0, 1);
        finish_run();
    end
endmodule
